// File: rtl/rs_syndrome_gen.sv
// rs_syndrome_gen: beat-serial RS(10,8) GF(2^8) syndrome generator with registered codeword/syndrome output
module rs_syndrome_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        beat_valid,
  output logic        beat_ready,
  input  logic [39:0] beat_data,
  input  logic        beat_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [79:0] cw_out,
  output logic [15:0] syn_out,
  output logic        syn_zero,
  output logic        frame_err,
  output logic [15:0] cw_count
);
  logic        phase_q, phase_d;
  logic [39:0] cw_hi_q, cw_hi_d;
  logic [7:0]  s0_p_q, s0_p_d, s1_p_q, s1_p_d;
  logic        out_valid_q, out_valid_d;
  logic [79:0] cw_q, cw_d;
  logic [15:0] syn_q, syn_d;
  logic        frame_err_q, frame_err_d;
  logic [15:0] cnt_q, cnt_d;
  logic        acc;
  logic [7:0]  s0_h, s1_h, s0_l, s1_l;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1D : 8'h00);
  endfunction

  // alpha^n * b as a chain of constant xtime stages, n <= 7
  function automatic logic [7:0] apow(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < 7; i++) r = (i < n) ? xt(r) : r;
    return r;
  endfunction

  assign beat_ready = !phase_q || !out_valid_q || out_ready;
  assign acc        = beat_valid && beat_ready;

  always_comb begin
    s0_h = '0;
    s1_h = '0;
    s0_l = s0_p_q ^ beat_data[15:8];
    s1_l = s1_p_q ^ beat_data[7:0];
    for (int k = 0; k < 5; k++) begin
      s0_h ^= beat_data[39-8*k -: 8];
      s1_h ^= apow(beat_data[39-8*k -: 8], k);
    end
    for (int k = 0; k < 3; k++) begin
      s0_l ^= beat_data[39-8*k -: 8];
      s1_l ^= apow(beat_data[39-8*k -: 8], k + 5);
    end
    phase_d     = phase_q;
    cw_hi_d     = cw_hi_q;
    s0_p_d      = s0_p_q;
    s1_p_d      = s1_p_q;
    out_valid_d = out_valid_q && !out_ready;
    cw_d        = cw_q;
    syn_d       = syn_q;
    cnt_d       = cnt_q;
    frame_err_d = acc && (beat_last ^ phase_q);
    if (acc && phase_q) begin
      cw_d        = {cw_hi_q, beat_data};
      syn_d       = {s0_l, s1_l};
      out_valid_d = 1'b1;
      phase_d     = 1'b0;
      cnt_d       = cnt_q + 16'd1;
    end else if (acc && !beat_last) begin
      cw_hi_d = beat_data;
      s0_p_d  = s0_h;
      s1_p_d  = s1_h;
      phase_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= 1'b0;
      cw_hi_q     <= '0;
      s0_p_q      <= '0;
      s1_p_q      <= '0;
      out_valid_q <= 1'b0;
      cw_q        <= '0;
      syn_q       <= '0;
      frame_err_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      phase_q     <= phase_d;
      cw_hi_q     <= cw_hi_d;
      s0_p_q      <= s0_p_d;
      s1_p_q      <= s1_p_d;
      out_valid_q <= out_valid_d;
      cw_q        <= cw_d;
      syn_q       <= syn_d;
      frame_err_q <= frame_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign cw_out    = cw_q;
  assign syn_out   = syn_q;
  assign syn_zero  = syn_q == 16'd0;
  assign frame_err = frame_err_q;
  assign cw_count  = cnt_q;
endmodule

// File: tb/tb_rs_syndrome_gen.sv
// tb_rs_syndrome_gen: random + directed checks of rs_syndrome_gen against a codeword-level GF(2^8) model
module tb_rs_syndrome_gen;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        beat_valid, beat_ready, beat_last, out_valid, out_ready, syn_zero, frame_err;
  logic [39:0] beat_data;
  logic [79:0] cw_out;
  logic [15:0] syn_out, cw_count;
  int          total = 0;
  int          bad = 0;
  logic        run = 1'b0;

  rs_syndrome_gen dut (
    .clk(clk), .rst_n(rst_n), .beat_valid(beat_valid), .beat_ready(beat_ready),
    .beat_data(beat_data), .beat_last(beat_last), .out_valid(out_valid), .out_ready(out_ready),
    .cw_out(cw_out), .syn_out(syn_out), .syn_zero(syn_zero), .frame_err(frame_err),
    .cw_count(cw_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gfmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
    end
    return r;
  endfunction

  function automatic logic [15:0] syndrome(input logic [79:0] cw);
    logic [7:0] s0, s1, ap, d;
    s0 = cw[15:8];
    s1 = cw[7:0];
    ap = 8'h01;
    for (int i = 0; i < 8; i++) begin
      d  = cw[79-8*i -: 8];
      s0 ^= d;
      s1 ^= gfmul(ap, d);
      ap = gfmul(ap, 8'h02);
    end
    return {s0, s1};
  endfunction

  function automatic logic [79:0] chip(input int i, input logic [7:0] v);
    return {v, 72'd0} >> (8 * i);
  endfunction

  logic        m_phase, m_ov, m_fe;
  logic [39:0] m_hi;
  logic [79:0] m_cw;
  logic [15:0] m_syn, m_cnt;
  logic        m_rdy, m_acc;
  assign m_rdy = !m_phase || !m_ov || out_ready;
  assign m_acc = beat_valid && m_rdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 1'b0; m_ov <= 1'b0; m_fe <= 1'b0; m_hi <= '0;
      m_cw <= '0; m_syn <= '0; m_cnt <= '0;
    end else begin
      m_fe <= m_acc && (m_phase ? !beat_last : beat_last);
      if (m_acc && m_phase) begin
        m_cw    <= {m_hi, beat_data};
        m_syn   <= syndrome({m_hi, beat_data});
        m_ov    <= 1'b1;
        m_cnt   <= m_cnt + 16'd1;
        m_phase <= 1'b0;
      end else begin
        if (out_ready) m_ov <= 1'b0;
        if (m_acc && !beat_last) begin
          m_hi    <= beat_data;
          m_phase <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (run) begin
    chk("m_beat_ready", 80'(beat_ready), 80'(m_rdy));
    chk("m_out_valid", 80'(out_valid), 80'(m_ov));
    chk("m_cw_out", cw_out, m_cw);
    chk("m_syn_out", 80'(syn_out), 80'(m_syn));
    chk("m_syn_zero", 80'(syn_zero), 80'(m_syn == 16'd0));
    chk("m_frame_err", 80'(frame_err), 80'(m_fe));
    chk("m_cw_count", 80'(cw_count), 80'(m_cnt));
  end

  task automatic drive_beat(input logic [39:0] d, input logic l);
    int n;
    n = 0;
    beat_valid = 1'b1; beat_data = d; beat_last = l;
    while (!beat_ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (!beat_ready) begin
      total++; bad++;
      $display("FAIL beat_timeout actual=0 required=1");
    end
    @(negedge clk); #1;
    beat_valid = 1'b0;
  endtask

  task automatic send(input logic [79:0] cw, input logic [15:0] es, input logic [15:0] ec);
    drive_beat(cw[79:40], 1'b0);
    drive_beat(cw[39:0], 1'b1);
    chk("lit_out_valid", 80'(out_valid), 80'(1'b1));
    chk("lit_cw_out", cw_out, cw);
    chk("lit_syn", 80'(syn_out), 80'(es));
    chk("lit_syn_zero", 80'(syn_zero), 80'(es == 16'd0));
    chk("lit_count", 80'(cw_count), 80'(ec));
  endtask

  task automatic chk_reset_vals();
    chk("rst_out_valid", 80'(out_valid), 80'(1'b0));
    chk("rst_cw_out", cw_out, 80'd0);
    chk("rst_syn", 80'(syn_out), 80'd0);
    chk("rst_syn_zero", 80'(syn_zero), 80'(1'b1));
    chk("rst_frame_err", 80'(frame_err), 80'(1'b0));
    chk("rst_count", 80'(cw_count), 80'd0);
    chk("rst_beat_ready", 80'(beat_ready), 80'(1'b1));
  endtask

  logic [79:0] cur, z;

  initial begin
    rst_n = 1'b0; beat_valid = 1'b0; beat_data = '0; beat_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_vals();
    rst_n = 1'b1;
    run = 1'b1;
    send(chip(1, 8'h01) | chip(8, 8'h01) | chip(9, 8'h02), 16'h0000, 16'd1);
    send(chip(1, 8'h80), 16'h801D, 16'd2);
    send(chip(3, 8'h01), 16'h0108, 16'd3);
    send(chip(7, 8'h01), 16'h0180, 16'd4);
    send(chip(8, 8'h44), 16'h4400, 16'd5);
    send(chip(9, 8'h33), 16'h0033, 16'd6);
    // stalled output: beat 0 accepted, beat 1 held off until out_ready
    out_ready = 1'b0;
    cur = chip(3, 8'h01);
    drive_beat(cur[79:40], 1'b0);
    chk("bp_ready_low", 80'(beat_ready), 80'(1'b0));
    beat_valid = 1'b1; beat_data = cur[39:0]; beat_last = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("bp_hold_valid", 80'(out_valid), 80'(1'b1));
    chk("bp_hold_syn", 80'(syn_out), 80'h0033);
    chk("bp_hold_ready", 80'(beat_ready), 80'(1'b0));
    out_ready = 1'b1;
    #1;
    chk("bp_ready_high", 80'(beat_ready), 80'(1'b1));
    @(negedge clk); #1;
    beat_valid = 1'b0;
    chk("bp_new_valid", 80'(out_valid), 80'(1'b1));
    chk("bp_new_syn", 80'(syn_out), 80'h0108);
    chk("bp_new_count", 80'(cw_count), 80'd7);
    // framing violations
    drive_beat(40'hDEADBEEF01, 1'b1);
    chk("fr0_err", 80'(frame_err), 80'(1'b1));
    chk("fr0_no_out", 80'(out_valid), 80'(1'b0));
    chk("fr0_count", 80'(cw_count), 80'd7);
    cur = chip(8, 8'h44);
    drive_beat(cur[79:40], 1'b0);
    drive_beat(cur[39:0], 1'b0);
    chk("fr1_err", 80'(frame_err), 80'(1'b1));
    chk("fr1_syn", 80'(syn_out), 80'h4400);
    chk("fr1_count", 80'(cw_count), 80'd8);
    @(negedge clk); #1;
    chk("fr1_err_pulse", 80'(frame_err), 80'(1'b0));
    // reset in phase 1 drops the partial
    cur = chip(1, 8'h80);
    drive_beat(cur[79:40], 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    @(negedge clk); #1;
    rst_n = 1'b1;
    send(chip(7, 8'h01), 16'h0180, 16'd1);
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
      end
      if (!m_phase) begin
        cur = {$urandom, $urandom, 16'($urandom)};
        if ($urandom_range(0, 2) == 0) begin
          z = cur & ~80'hFFFF;
          cur = z | 80'(syndrome(z));
        end
      end
      beat_valid = $urandom_range(0, 3) != 0;
      out_ready  = $urandom_range(0, 3) != 0;
      beat_last  = ($urandom_range(0, 9) == 0) ? !m_phase : m_phase;
      beat_data  = m_phase ? cur[39:0] : cur[79:40];
    end
    @(negedge clk); #1;
    beat_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
